// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin port onto an 8x16 register file, with a zeroing init sweep after reset or clear.
// Grants are combinational, and read data returns one cycle after the accept. A requester that loses arbitration waits with ready low.
module regfile_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              init_done
);

  localparam logic [1:0] INIT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              last_b;
  logic              open;
  logic              gnt_a;
  logic              gnt_b;
  logic              rd_a;
  logic              rd_b;

  // Ready depends only on the valids, the state and last_grant, never on the other ready.
  assign open      = (state == RUN) && !clear;
  assign gnt_a     = open && a_valid && (!b_valid || last_b);
  assign gnt_b     = open && b_valid && (!a_valid || !last_b);
  assign a_ready   = gnt_a;
  assign b_ready   = gnt_b;
  assign rd_a      = gnt_a && !a_write;
  assign rd_b      = gnt_b && !b_write;
  assign init_done = (state == RUN);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_raddr = '0;
    if (state == INIT) begin
      rf_we    = 1'b1;
      rf_waddr = cnt;
    end else if (gnt_a) begin
      if (a_write) begin
        rf_we    = 1'b1;
        rf_waddr = a_addr;
        rf_wdata = a_wdata;
      end else begin
        rf_raddr = a_addr;
      end
    end else if (gnt_b) begin
      if (b_write) begin
        rf_we    = 1'b1;
        rf_waddr = b_addr;
        rf_wdata = b_wdata;
      end else begin
        rf_raddr = b_addr;
      end
    end
    // The state already reads INIT during reset, so the sweep write has to be masked here.
    if (!rst) rf_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INIT;
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= RUN;
        end
        RUN: begin
          if (clear) begin
            state <= INIT;
            cnt   <= '0;
          end else if (gnt_a) begin
            last_b <= 1'b0;
          end else if (gnt_b) begin
            last_b <= 1'b1;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= rd_a;
      b_rvalid <= rd_b;
      if (rd_a) a_rdata <= rf_rdata;
      if (rd_b) b_rdata <= rf_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios plus a randomized run against a register-level model.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        a_valid = 1'b0, a_write = 1'b0;
  logic [2:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        b_valid = 1'b0, b_write = 1'b0;
  logic [2:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        a_ready, a_rvalid, b_ready, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr, rf_raddr;
  logic [15:0] rf_wdata, rf_rdata;
  logic        init_done;
  logic        scramble = 1'b0;

  logic [15:0] rf_mem [8];

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] m_mem [8];
  bit          m_run, m_lastb, m_arv, m_brv;
  int          m_cnt;
  logic [15:0] m_ard, m_brd;

  // Expected and observed values for the current cycle
  logic        ex_ag, ex_bg, ex_we, ex_arv, ex_brv, ex_done;
  logic [2:0]  ex_waddr, ex_raddr;
  logic [15:0] ex_wdata, ex_ard, ex_brd;
  logic        ob_ag, ob_bg, ob_we, ob_arv, ob_brv, ob_done;
  logic [2:0]  ob_waddr, ob_raddr;
  logic [15:0] ob_wdata, ob_ard, ob_brd;

  regfile_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .a_valid(a_valid), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Register file: combinational read and a write on the edge. While scrambling it is filled with garbage
  // so that the effect of the sweep can be seen.
  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    else if (scramble) rf_mem[3'($urandom_range(7))] <= 16'($urandom);
  end

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_lastb = 1; m_arv = 0; m_brv = 0; m_ard = '0; m_brd = '0;
  endtask

  // Called just after a rising edge once the inputs are set. It samples the DUT mid-cycle,
  // then lets the edge pass and advances the model.
  task automatic cycle();
    #2;
    ex_ag = 0; ex_bg = 0; ex_we = 0; ex_waddr = '0; ex_wdata = '0; ex_raddr = '0;
    if (!m_run) begin
      ex_we = 1; ex_waddr = 3'(m_cnt);
    end else if (!clear) begin
      if (a_valid && b_valid) begin ex_ag = m_lastb; ex_bg = !m_lastb; end
      else begin ex_ag = a_valid; ex_bg = b_valid; end
      if (ex_ag) begin
        if (a_write) begin ex_we = 1; ex_waddr = a_addr; ex_wdata = a_wdata; end
        else ex_raddr = a_addr;
      end
      if (ex_bg) begin
        if (b_write) begin ex_we = 1; ex_waddr = b_addr; ex_wdata = b_wdata; end
        else ex_raddr = b_addr;
      end
    end
    ex_done = m_run; ex_arv = m_arv; ex_ard = m_ard; ex_brv = m_brv; ex_brd = m_brd;
    ob_ag = a_ready; ob_bg = b_ready; ob_we = rf_we; ob_waddr = rf_waddr; ob_wdata = rf_wdata;
    ob_raddr = rf_raddr; ob_arv = a_rvalid; ob_ard = a_rdata; ob_brv = b_rvalid; ob_brd = b_rdata;
    ob_done = init_done;
    @(posedge clk);
    m_arv = 0; m_brv = 0;
    if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 8) begin m_run = 1; m_cnt = 0; end
    end else if (clear) begin
      m_run = 0; m_cnt = 0;
    end else if (ex_ag) begin
      m_lastb = 0;
      if (a_write) m_mem[a_addr] = a_wdata;
      else begin m_arv = 1; m_ard = m_mem[a_addr]; end
    end else if (ex_bg) begin
      m_lastb = 1;
      if (b_write) m_mem[b_addr] = b_wdata;
      else begin m_brv = 1; m_brd = m_mem[b_addr]; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; scramble = 1; a_valid = 1; b_valid = 1; model_reset();
    repeat (4) @(posedge clk);
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready); end
    total++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b%b exp=00", a_rvalid, b_rvalid); end
    total++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", a_rdata, b_rdata); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    scramble = 0; b_valid = 0;
  endtask

  task automatic test_init_sweep();
    a_write = 0; a_addr = 3'd2; rst = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      total++; if (ob_we !== 1'b1 || ob_waddr !== 3'(i) || ob_wdata !== 16'h0) begin
        bad++; $display("FAIL init_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=0", i, ob_we, ob_waddr, ob_wdata, i);
      end
      total++; if (ob_ag !== 1'b0 || ob_done !== 1'b0) begin
        bad++; $display("FAIL init_ready[%0d] got a_ready=%b init_done=%b exp 0/0", i, ob_ag, ob_done);
      end
    end
    a_valid = 0;
    cycle();
    total++; if (ob_done !== 1'b1 || ob_we !== 1'b0) begin bad++; $display("FAIL init_done_cycle9 got done=%b we=%b exp 1/0", ob_done, ob_we); end
  endtask

  task automatic test_write_read();
    a_valid = 1; a_write = 1; a_addr = 3'd5; a_wdata = 16'h1234;
    cycle();
    total++; if (ob_ag !== 1'b1 || ob_we !== 1'b1 || ob_waddr !== 3'd5 || ob_wdata !== 16'h1234) begin
      bad++; $display("FAIL wr_accept got rdy=%b we=%b addr=%0d data=%h exp 1/1/5/1234", ob_ag, ob_we, ob_waddr, ob_wdata);
    end
    a_write = 0;
    cycle();
    total++; if (ob_ag !== 1'b1 || ob_raddr !== 3'd5 || ob_we !== 1'b0 || ob_arv !== 1'b0) begin
      bad++; $display("FAIL rd_accept got rdy=%b raddr=%0d we=%b rvalid=%b exp 1/5/0/0", ob_ag, ob_raddr, ob_we, ob_arv);
    end
    a_valid = 0;
    cycle();
    total++; if (ob_arv !== 1'b1 || ob_ard !== 16'h1234 || ob_brv !== 1'b0) begin
      bad++; $display("FAIL rd_response got rvalid=%b rdata=%h b_rvalid=%b exp 1/1234/0", ob_arv, ob_ard, ob_brv);
    end
    cycle();
    total++; if (ob_arv !== 1'b0 || ob_ard !== 16'h1234) begin
      bad++; $display("FAIL rd_hold got rvalid=%b rdata=%h exp 0/1234", ob_arv, ob_ard);
    end
  endtask

  task automatic test_contention();
    a_valid = 1; a_write = 1; a_addr = 3'd1; a_wdata = 16'hA1A1;
    cycle();
    a_valid = 0; b_valid = 1; b_write = 1; b_addr = 3'd2; b_wdata = 16'hB2B2;
    cycle();
    a_valid = 1; a_write = 0; b_write = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      total++; if (ob_ag !== (k % 2 == 0) || ob_bg !== (k % 2 == 1)) begin
        bad++; $display("FAIL rr_grant[%0d] got a=%b b=%b exp a=%b", k, ob_ag, ob_bg, k % 2 == 0);
      end
      if (k > 0) begin
        total++; if (ob_arv !== (k % 2 == 1) || ob_brv !== (k % 2 == 0)) begin
          bad++; $display("FAIL rr_rvalid[%0d] got a=%b b=%b exp a=%b", k, ob_arv, ob_brv, k % 2 == 1);
        end
        total++; if ((k % 2 == 1 && ob_ard !== 16'hA1A1) || (k % 2 == 0 && ob_brd !== 16'hB2B2)) begin
          bad++; $display("FAIL rr_rdata[%0d] got a=%h b=%h exp a=A1A1 b=B2B2", k, ob_ard, ob_brd);
        end
      end
    end
    a_valid = 0; b_valid = 0;
    cycle();
  endtask

  task automatic test_priority();
    b_valid = 1; b_write = 1; b_addr = 3'd3; b_wdata = 16'hBEEF;
    cycle();
    total++; if (ob_bg !== 1'b1 || ob_wdata !== 16'hBEEF) begin bad++; $display("FAIL prio_b_write got rdy=%b data=%h exp 1/BEEF", ob_bg, ob_wdata); end
    b_write = 0; a_valid = 1; a_write = 1; a_addr = 3'd3; a_wdata = 16'h0001;
    cycle();
    total++; if (ob_ag !== 1'b1 || ob_bg !== 1'b0 || ob_wdata !== 16'h0001) begin
      bad++; $display("FAIL prio_a_wins got a=%b b=%b data=%h exp 1/0/0001", ob_ag, ob_bg, ob_wdata);
    end
    a_valid = 0;
    cycle();
    total++; if (ob_bg !== 1'b1 || ob_raddr !== 3'd3) begin bad++; $display("FAIL prio_b_read got rdy=%b raddr=%0d exp 1/3", ob_bg, ob_raddr); end
    b_valid = 0;
    cycle();
    total++; if (ob_brv !== 1'b1 || ob_brd !== 16'h0001) begin bad++; $display("FAIL prio_r3 got rvalid=%b data=%h exp 1/0001", ob_brv, ob_brd); end
  endtask

  task automatic test_clear();
    a_valid = 1; a_write = 1; a_addr = 3'd4; a_wdata = 16'h00FF;
    cycle();
    a_write = 0; clear = 1;
    cycle();
    total++; if (ob_ag !== 1'b0 || ob_we !== 1'b0 || ob_done !== 1'b1) begin
      bad++; $display("FAIL clear_cycle got rdy=%b we=%b done=%b exp 0/0/1", ob_ag, ob_we, ob_done);
    end
    clear = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) clear = 1;
      if (i == 4) clear = 0;
      cycle();
      total++; if (ob_we !== 1'b1 || ob_waddr !== 3'(i) || ob_ag !== 1'b0) begin
        bad++; $display("FAIL clear_sweep[%0d] got we=%b addr=%0d rdy=%b exp 1/%0d/0", i, ob_we, ob_waddr, ob_ag, i);
      end
    end
    cycle();
    total++; if (ob_ag !== 1'b1) begin bad++; $display("FAIL clear_read_accept got rdy=%b exp 1", ob_ag); end
    a_valid = 0;
    cycle();
    total++; if (ob_arv !== 1'b1 || ob_ard !== 16'h0000) begin bad++; $display("FAIL clear_r4 got rvalid=%b data=%h exp 1/0000", ob_arv, ob_ard); end
  endtask

  task automatic test_reset_midop();
    a_valid = 1; a_write = 1; a_addr = 3'd6; a_wdata = 16'h5A5A;
    cycle();
    a_write = 0;
    cycle();
    a_valid = 0;
    cycle();
    total++; if (ob_ard !== 16'h5A5A) begin bad++; $display("FAIL midrst_preload got rdata=%h exp 5A5A", ob_ard); end
    a_valid = 1;
    #2;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL midrst_accept got rdy=%b exp 1", a_ready); end
    @(posedge clk);
    rst = 0;
    #1;
    total++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL midrst_cancel got rvalid=%b rdata=%h we=%b exp 0/0000/0", a_rvalid, a_rdata, rf_we);
    end
    model_reset(); scramble = 1; a_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    scramble = 0; rst = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      total++; if (ob_we !== 1'b1 || ob_waddr !== 3'(i) || ob_arv !== 1'b0) begin
        bad++; $display("FAIL midrst_sweep[%0d] got we=%b addr=%0d rvalid=%b exp 1/%0d/0", i, ob_we, ob_waddr, ob_arv, i);
      end
    end
  endtask

  task automatic test_random();
    bit a_held, b_held;
    a_held = 0; b_held = 0;
    for (int n = 0; n < 600; n++) begin
      // A requester still waiting normally holds its request, but now and then it withdraws.
      if (!(a_held && $urandom_range(9) != 0)) begin
        a_valid = ($urandom_range(3) != 0); a_write = $urandom_range(1) == 1;
        a_addr = 3'($urandom_range(7)); a_wdata = 16'($urandom);
      end
      if (!(b_held && $urandom_range(9) != 0)) begin
        b_valid = ($urandom_range(3) != 0); b_write = $urandom_range(1) == 1;
        b_addr = 3'($urandom_range(7)); b_wdata = 16'($urandom);
      end
      clear = ($urandom_range(49) == 0);
      cycle();
      a_held = a_valid && !ob_ag;
      b_held = b_valid && !ob_bg;
      total++; if (ob_ag !== ex_ag || ob_bg !== ex_bg) begin bad++; $display("FAIL rnd_grant[%0d] got %b%b exp %b%b", n, ob_ag, ob_bg, ex_ag, ex_bg); end
      total++; if (ob_we !== ex_we || ob_waddr !== ex_waddr || ob_wdata !== ex_wdata) begin
        bad++; $display("FAIL rnd_write[%0d] got %b/%0d/%h exp %b/%0d/%h", n, ob_we, ob_waddr, ob_wdata, ex_we, ex_waddr, ex_wdata);
      end
      total++; if (ob_raddr !== ex_raddr) begin bad++; $display("FAIL rnd_raddr[%0d] got %0d exp %0d", n, ob_raddr, ex_raddr); end
      total++; if (ob_arv !== ex_arv || ob_ard !== ex_ard) begin bad++; $display("FAIL rnd_a_resp[%0d] got %b/%h exp %b/%h", n, ob_arv, ob_ard, ex_arv, ex_ard); end
      total++; if (ob_brv !== ex_brv || ob_brd !== ex_brd) begin bad++; $display("FAIL rnd_b_resp[%0d] got %b/%h exp %b/%h", n, ob_brv, ob_brd, ex_brv, ex_brd); end
      total++; if (ob_done !== ex_done) begin bad++; $display("FAIL rnd_done[%0d] got %b exp %b", n, ob_done, ex_done); end
    end
    a_valid = 0; b_valid = 0; clear = 0;
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_write_read();
    test_contention();
    test_priority();
    test_clear();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
